// File: rtl/core_mem_ctrl.sv
// Fetch sequencer between core memory (WMEM / KV cache) and the LBUF row buffer.
// Optional performance counters are compiled in when CORE_MEM_CTRL_PERF_EN is defined.
module core_mem_ctrl #(
    parameter int unsigned GBUS_DATA  = 64,
    parameter int unsigned GBUS_ADDR  = 12,
    parameter int unsigned LBUF_DATA  = 512,
    parameter int unsigned LBUF_DEPTH = 16,
    parameter int unsigned LBUF_ADDR  = $clog2(LBUF_DEPTH),
    parameter int unsigned ROW_W      = 8,
    parameter int unsigned S2P_LAT    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [GBUS_ADDR-1:0] cmd_base_i,
    input  logic [ROW_W-1:0]     cmd_rows_i,
    input  logic                 cmem_stall_i,
    output logic [GBUS_ADDR-1:0] cmem_raddr_o,
    output logic                 cmem_ren_o,
    output logic [LBUF_ADDR-1:0] lbuf_waddr_o,
    output logic [LBUF_ADDR-1:0] lbuf_raddr_o,
    output logic                 lbuf_ren_o,
    input  logic                 mac_rd_req_i,
    output logic [LBUF_ADDR:0]   lbuf_count_o,
    output logic                 busy_o,
`ifdef CORE_MEM_CTRL_PERF_EN
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          beat_cnt_o,
`endif
    output logic                 done_o
);

    localparam int unsigned W      = LBUF_DATA / GBUS_DATA;
    localparam int unsigned BEAT_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CNT_W  = LBUF_ADDR + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic [GBUS_ADDR-1:0] base_q, base_d;
    logic [GBUS_ADDR-1:0] words_q, words_d;
    logic [ROW_W-1:0]     rows_q, rows_d;
    logic [ROW_W-1:0]     rows_issued_q, rows_issued_d;
    logic [ROW_W-1:0]     rows_commit_q, rows_commit_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]     reserved_q, reserved_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [LBUF_ADDR-1:0] waddr_q, waddr_d;
    logic [LBUF_ADDR-1:0] raddr_q, raddr_d;
    logic [S2P_LAT:0]     lb_sr_q, lb_sr_d;

    logic beat_zero, last_beat, last_row, commit, row_open;

    assign beat_zero = (beat_q == '0);
    assign last_beat = (beat_q == BEAT_W'(W - 1));
    assign last_row  = (rows_issued_q == rows_q - ROW_W'(1));
    // A new row may only start once an LBUF slot is reserved for it.
    assign row_open  = !beat_zero || (reserved_q < CNT_W'(LBUF_DEPTH));
    assign commit    = lb_sr_q[S2P_LAT];

    assign cmem_ren_o   = (state_q == StFetch) && !cmem_stall_i && row_open;
    assign cmem_raddr_o = base_q + words_q;
    assign lbuf_ren_o   = mac_rd_req_i && (count_q != '0) &&
                          ((state_q == StFetch) || (state_q == StDrain));
    assign lbuf_waddr_o = waddr_q;
    assign lbuf_raddr_o = raddr_q;
    assign lbuf_count_o = count_q;
    assign busy_o       = (state_q != StIdle);
    assign cmd_ready_o  = ready_q;
    assign done_o       = done_q;

    // Bit 0 marks the response cycle of a row's last beat; the top bit is the commit strobe.
    always_comb begin
        lb_sr_d    = '0;
        lb_sr_d[0] = cmem_ren_o && last_beat;
        for (int i = 1; i <= int'(S2P_LAT); i++) begin
            lb_sr_d[i] = lb_sr_q[i-1];
        end
    end

    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        base_d        = base_q;
        words_d       = words_q;
        rows_d        = rows_q;
        rows_issued_d = rows_issued_q;
        rows_commit_d = rows_commit_q;
        beat_d        = beat_q;
        waddr_d       = waddr_q;
        raddr_d       = raddr_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i && ready_q) begin
                    base_d        = cmd_base_i;
                    rows_d        = cmd_rows_i;
                    words_d       = '0;
                    beat_d        = '0;
                    rows_issued_d = '0;
                    rows_commit_d = '0;
                    if (cmd_rows_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (cmem_ren_o) begin
                    words_d = words_q + GBUS_ADDR'(1);
                    beat_d  = last_beat ? '0 : beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        rows_issued_d = rows_issued_q + ROW_W'(1);
                        if (last_row) begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if ((rows_commit_q == rows_q) && (count_q == '0)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (commit) begin
            waddr_d       = waddr_q + LBUF_ADDR'(1);
            rows_commit_d = rows_commit_d + ROW_W'(1);
        end
        if (lbuf_ren_o) begin
            raddr_d = raddr_q + LBUF_ADDR'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({commit, lbuf_ren_o})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        reserved_d = reserved_q;
        case ({cmem_ren_o && beat_zero, lbuf_ren_o})
            2'b10:   reserved_d = reserved_q + CNT_W'(1);
            2'b01:   reserved_d = reserved_q - CNT_W'(1);
            default: reserved_d = reserved_q;
        endcase
    end

    // Registered ready keeps every output low while reset is asserted.
    assign ready_d = (state_d == StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            base_q        <= '0;
            words_q       <= '0;
            rows_q        <= '0;
            rows_issued_q <= '0;
            rows_commit_q <= '0;
            beat_q        <= '0;
            reserved_q    <= '0;
            count_q       <= '0;
            waddr_q       <= '0;
            raddr_q       <= '0;
            lb_sr_q       <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            base_q        <= base_d;
            words_q       <= words_d;
            rows_q        <= rows_d;
            rows_issued_q <= rows_issued_d;
            rows_commit_q <= rows_commit_d;
            beat_q        <= beat_d;
            reserved_q    <= reserved_d;
            count_q       <= count_d;
            waddr_q       <= waddr_d;
            raddr_q       <= raddr_d;
            lb_sr_q       <= lb_sr_d;
        end
    end

`ifdef CORE_MEM_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if ((state_q == StFetch) && !cmem_ren_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (cmem_ren_o && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign beat_cnt_o  = beat_cnt_q;
`endif

endmodule
